ppu_stream: RTL and testbench

//  Parametrised, pipelined post-processing unit for accelerator output vectors.

---
 rtl/ppu_stream.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ppu_stream.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_stream.sv
// ppu_stream: streaming post-processing of accumulator vectors.
// Per-row scale and bias, optional ReLU, rounding right shift (half away
// from zero), symmetric saturation, and per-tile abs-max reporting.
module ppu_stream #(
    parameter int VL      = 16,
    parameter int ACC_W   = 24,
    parameter int SCALE_W = 16,
    parameter int BIAS_W  = 32,
    parameter int OUT_W   = 18,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int SHIFT_W = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [CNT_W-1:0]           i_num_vec,
    input  logic                       i_relu_en,
    input  logic [SHIFT_W-1:0]         i_shift,
    input  logic                       i_cfg_we,
    input  logic                       i_cfg_sel,
    input  logic [$clog2(DEPTH)-1:0]   i_cfg_addr,
    input  logic [BIAS_W*VL-1:0]       i_cfg_data,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [ACC_W*VL-1:0]        i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [OUT_W*VL-1:0]        o_out_data,
    output logic [$clog2(DEPTH)-1:0]   o_out_row,
    output logic [OUT_W-2:0]           o_absmax,
    output logic                       o_absmax_valid,
    output logic                       o_sat,
    output logic                       o_busy,
    output logic                       o_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ACC_W + SCALE_W;
    localparam int FW = PW + 1;
    localparam int MW = OUT_W - 1;
    localparam logic [FW:0]     MAX_R    = {{(FW + 1 - MW){1'b0}}, {MW{1'b1}}};
    localparam logic [FW-1:0]   ONE_FW   = FW'(1);
    localparam logic [OUT_W-1:0] ONE_OUT = OUT_W'(1);
    localparam logic [AW-1:0]   LAST_ROW = AW'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_t;
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [MW-1:0]    mag;
        logic             sat;
    } lane_res_t;

    // acc*scale + sign-extended bias, full precision
    function automatic logic [FW-1:0] mac_lane(input logic signed [ACC_W-1:0] acc,
                                               input logic signed [SCALE_W-1:0] sc,
                                               input logic signed [BIAS_W-1:0] bi);
        logic signed [PW-1:0] p;
        p = acc * sc;
        return {p[PW-1], p} + {{(FW - BIAS_W){bi[BIAS_W-1]}}, bi};
    endfunction

    // ReLU, magnitude rounding shift, symmetric saturation, sign restore
    function automatic lane_res_t post_lane(input logic [FW-1:0] s_in, input logic relu,
                                            input logic [SHIFT_W-1:0] sh);
        logic [FW-1:0] s;
        logic [FW-1:0] a;
        logic [FW-1:0] rb_vec;
        logic [FW:0]   r;
        lane_res_t     res;
        s      = (relu && (s_in[FW-1] || (s_in == '0))) ? '0 : s_in;
        a      = s[FW-1] ? ((~s) + ONE_FW) : s;
        rb_vec = a >> (sh - SHIFT_W'(1));
        r      = {1'b0, (a >> sh)} + {{FW{1'b0}}, (rb_vec[0] && (sh != '0))};
        res.sat  = (r > MAX_R);
        res.mag  = res.sat ? {MW{1'b1}} : r[MW-1:0];
        res.data = s[FW-1] ? ((~{1'b0, res.mag}) + ONE_OUT) : {1'b0, res.mag};
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      num_vec_q, num_vec_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic                  relu_q, relu_d, sat_q, sat_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [AW-1:0]         row_q, row_d;
    logic                  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, out_valid_q, out_valid_d;
    logic [ACC_W*VL-1:0]   s1_acc_q, s1_acc_d;
    logic [SCALE_W*VL-1:0] s1_scale_q, s1_scale_d;
    logic [BIAS_W*VL-1:0]  s1_bias_q, s1_bias_d;
    logic [AW-1:0]         s1_row_q, s1_row_d, s2_row_q, s2_row_d, out_row_q, out_row_d;
    logic [FW*VL-1:0]      s2_sum_q, s2_sum_d, s2_sum_s;
    logic [OUT_W*VL-1:0]   out_data_q, out_data_d, s3_data_s;
    logic [MW-1:0]         out_max_q, out_max_d, s3_max_s;
    logic [MW-1:0]         tile_max_q, tile_max_d, absmax_q, absmax_d, new_max_s;
    logic                  absmax_valid_q, absmax_valid_d;
    logic                  s3_sat_s, stall_s, in_fire_s, out_fire_s, out_last_s, cfg_we_s;
    logic [SCALE_W*VL-1:0] cfg_scale_s;
    logic [SCALE_W*VL-1:0] scale_mem [DEPTH];
    logic [BIAS_W*VL-1:0]  bias_mem  [DEPTH];

    assign stall_s    = out_valid_q && !i_out_ready;
    assign o_in_ready = (state_q == ST_RUN) && !stall_s;
    assign in_fire_s  = i_in_valid && o_in_ready;
    assign out_fire_s = out_valid_q && i_out_ready;
    assign out_last_s = (out_cnt_q == (num_vec_q - CNT_W'(1)));
    assign cfg_we_s   = i_cfg_we && (state_q == ST_IDLE);

    // Scale rows keep only the low SCALE_W bits of each cfg lane
    always_comb begin
        cfg_scale_s = '0;
        for (int i = 0; i < VL; i++) begin
            cfg_scale_s[i*SCALE_W +: SCALE_W] = i_cfg_data[i*BIAS_W +: SCALE_W];
        end
    end

    // Table write port; table contents are deliberately left unreset
    always_ff @(posedge i_clk) begin
        if (cfg_we_s) begin
            if (i_cfg_sel) bias_mem[i_cfg_addr]  <= i_cfg_data;
            else           scale_mem[i_cfg_addr] <= cfg_scale_s;
        end
    end

    // Stage-2 arithmetic: per-lane multiply-add
    always_comb begin
        s2_sum_s = '0;
        for (int i = 0; i < VL; i++) begin
            s2_sum_s[i*FW +: FW] = mac_lane(s1_acc_q[i*ACC_W +: ACC_W],
                                            s1_scale_q[i*SCALE_W +: SCALE_W],
                                            s1_bias_q[i*BIAS_W +: BIAS_W]);
        end
    end

    // Stage-3 arithmetic: rounding, saturation, vector magnitude max
    always_comb begin
        lane_res_t res;
        res       = '0;
        s3_data_s = '0;
        s3_max_s  = '0;
        s3_sat_s  = 1'b0;
        for (int i = 0; i < VL; i++) begin
            res = post_lane(s2_sum_q[i*FW +: FW], relu_q, shift_q);
            s3_data_s[i*OUT_W +: OUT_W] = res.data;
            if (res.mag > s3_max_s) s3_max_s = res.mag;
            else                    s3_max_s = s3_max_s;
            s3_sat_s = s3_sat_s | res.sat;
        end
    end

    // Job control FSM and counters
    always_comb begin
        state_d   = state_q;
        num_vec_d = num_vec_q;
        relu_d    = relu_q;
        shift_d   = shift_q;
        row_d     = row_q;
        in_cnt_d  = in_cnt_q;
        if (out_fire_s) out_cnt_d = out_cnt_q + CNT_W'(1);
        else            out_cnt_d = out_cnt_q;
        if (!stall_s && s2_valid_q && s3_sat_s) sat_d = 1'b1;
        else                                     sat_d = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    num_vec_d = i_num_vec;
                    relu_d    = i_relu_en;
                    shift_d   = i_shift;
                    row_d     = '0;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    sat_d     = 1'b0;
                    state_d   = (i_num_vec == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_fire_s) begin
                    row_d    = (row_q == LAST_ROW) ? '0 : (row_q + AW'(1));
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if ((in_cnt_q + CNT_W'(1)) == num_vec_q) state_d = ST_DRAIN;
                    else                                     state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_fire_s && out_last_s) state_d = ST_DONE;
                else                          state_d = ST_DRAIN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Three-stage pipeline; every stage freezes together under backpressure
    always_comb begin
        s1_valid_d = s1_valid_q;  s1_acc_d = s1_acc_q;   s1_row_d = s1_row_q;
        s1_scale_d = s1_scale_q;  s1_bias_d = s1_bias_q;
        s2_valid_d = s2_valid_q;  s2_sum_d = s2_sum_q;   s2_row_d = s2_row_q;
        out_valid_d = out_valid_q; out_data_d = out_data_q; out_row_d = out_row_q;
        out_max_d  = out_max_q;
        if (!stall_s) begin
            s1_valid_d  = in_fire_s;
            s1_acc_d    = i_in_data;
            s1_row_d    = row_q;
            s1_scale_d  = scale_mem[row_q];
            s1_bias_d   = bias_mem[row_q];
            s2_valid_d  = s1_valid_q;
            s2_sum_d    = s2_sum_s;
            s2_row_d    = s1_row_q;
            out_valid_d = s2_valid_q;
            out_data_d  = s3_data_s;
            out_row_d   = s2_row_q;
            out_max_d   = s3_max_s;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Tile abs-max: fold each handshaked vector, publish and clear at tile end
    always_comb begin
        new_max_s      = (out_max_q > tile_max_q) ? out_max_q : tile_max_q;
        tile_max_d     = tile_max_q;
        absmax_d       = absmax_q;
        absmax_valid_d = 1'b0;
        if (out_fire_s) begin
            absmax_d = new_max_s;
            if ((out_row_q == LAST_ROW) || out_last_s) begin
                absmax_valid_d = 1'b1;
                tile_max_d     = '0;
            end else begin
                tile_max_d = new_max_s;
            end
        end else begin
            absmax_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;     num_vec_q <= '0;   relu_q <= 1'b0;    shift_q <= '0;
            row_q <= '0;            in_cnt_q <= '0;    out_cnt_q <= '0;   sat_q <= 1'b0;
            s1_valid_q <= 1'b0;     s1_acc_q <= '0;    s1_row_q <= '0;
            s1_scale_q <= '0;       s1_bias_q <= '0;
            s2_valid_q <= 1'b0;     s2_sum_q <= '0;    s2_row_q <= '0;
            out_valid_q <= 1'b0;    out_data_q <= '0;  out_row_q <= '0;   out_max_q <= '0;
            tile_max_q <= '0;       absmax_q <= '0;    absmax_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;     num_vec_q <= num_vec_d; relu_q <= relu_d; shift_q <= shift_d;
            row_q <= row_d;         in_cnt_q <= in_cnt_d;   out_cnt_q <= out_cnt_d; sat_q <= sat_d;
            s1_valid_q <= s1_valid_d; s1_acc_q <= s1_acc_d; s1_row_q <= s1_row_d;
            s1_scale_q <= s1_scale_d; s1_bias_q <= s1_bias_d;
            s2_valid_q <= s2_valid_d; s2_sum_q <= s2_sum_d; s2_row_q <= s2_row_d;
            out_valid_q <= out_valid_d; out_data_q <= out_data_d; out_row_q <= out_row_d;
            out_max_q <= out_max_d;
            tile_max_q <= tile_max_d; absmax_q <= absmax_d; absmax_valid_q <= absmax_valid_d;
        end
    end

    assign o_out_valid    = out_valid_q;
    assign o_out_data     = out_data_q;
    assign o_out_row      = out_row_q;
    assign o_absmax       = absmax_q;
    assign o_absmax_valid = absmax_valid_q;
    assign o_sat          = sat_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_done         = (state_q == ST_DONE);
endmodule

// File: tb/tb_ppu_stream.sv
// Directed and randomized-handshake bench for ppu_stream.
module tb_ppu_stream;
    localparam int VL = 16, ACC_W = 24, SCALE_W = 16, BIAS_W = 32, OUT_W = 18;
    localparam int DEPTH = 16, CNT_W = 16, SHIFT_W = 6, AW = 4;
    typedef logic [OUT_W*VL-1:0]  ovec_t;
    typedef logic [ACC_W*VL-1:0]  ivec_t;
    typedef logic [BIAS_W*VL-1:0] cvec_t;

    logic i_clk, i_rst_n, i_start, i_relu_en, i_cfg_we, i_cfg_sel;
    logic [CNT_W-1:0] i_num_vec;
    logic [SHIFT_W-1:0] i_shift;
    logic [AW-1:0] i_cfg_addr, o_out_row;
    cvec_t i_cfg_data;
    logic i_in_valid, o_in_ready, o_out_valid, i_out_ready;
    ivec_t i_in_data;
    ovec_t o_out_data;
    logic [OUT_W-2:0] o_absmax;
    logic o_absmax_valid, o_sat, o_busy, o_done;

    ppu_stream dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_vec(i_num_vec),
        .i_relu_en(i_relu_en), .i_shift(i_shift), .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel),
        .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .i_in_data(i_in_data), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_row(o_out_row),
        .o_absmax(o_absmax), .o_absmax_valid(o_absmax_valid), .o_sat(o_sat),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, hs_cyc = -1, first_valid_cyc = -1, done_cnt = 0;
    bit in_hs = 1'b0, was_stall = 1'b0;
    ovec_t held_data;
    logic [AW-1:0] held_row;
    ivec_t in_q[$];
    ovec_t exp_q[$];
    logic [AW-1:0] exp_row_q[$];
    logic [OUT_W-2:0] am_q[$];
    int sc_tab[DEPTH][VL], bi_tab[DEPTH][VL];

    task automatic check(input string tag, input ovec_t obs, input ovec_t exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ivec_t rep_i(input longint v);
        ivec_t r;
        for (int i = 0; i < VL; i++) r[i*ACC_W +: ACC_W] = v[ACC_W-1:0];
        return r;
    endfunction

    function automatic ovec_t rep_o(input longint v);
        ovec_t r;
        for (int i = 0; i < VL; i++) r[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
        return r;
    endfunction

    function automatic cvec_t rep_c(input longint v);
        cvec_t r;
        for (int i = 0; i < VL; i++) r[i*BIAS_W +: BIAS_W] = v[BIAS_W-1:0];
        return r;
    endfunction

    function automatic ovec_t am_at(input int k);
        if (k < am_q.size()) return ovec_t'(am_q[k]);
        return '1;
    endfunction

    // Reference: round by adding half then truncating the magnitude
    function automatic longint ref_lane(input longint acc, input longint sc, input longint bi,
                                        input bit relu, input int sh);
        longint v, m, r;
        v = acc * sc + bi;
        if (relu && v < 64'sd0) v = 64'sd0;
        m = (v < 64'sd0) ? -v : v;
        r = (sh == 0) ? m : ((m + (64'sd1 <<< (sh - 1))) >>> sh);
        if (r > 64'sd131071) r = 64'sd131071;
        return (v < 64'sd0) ? -r : r;
    endfunction

    // Monitor: handshakes, stability under stall, pulses
    initial forever @(posedge i_clk) cyc++;
    initial forever begin
        @(negedge i_clk);
        in_hs = i_in_valid && o_in_ready;
        if (in_hs && hs_cyc < 0) hs_cyc = cyc;
        if (o_out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (was_stall) begin
            check("hold_valid", ovec_t'(o_out_valid), ovec_t'(1));
            check("hold_data", o_out_data, held_data);
            check("hold_row", ovec_t'(o_out_row), ovec_t'(held_row));
        end
        was_stall = o_out_valid && !i_out_ready;
        held_data = o_out_data;
        held_row  = o_out_row;
        if (o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) check("extra_out", ovec_t'(1), ovec_t'(0));
            else begin
                check("out_data", o_out_data, exp_q.pop_front());
                check("out_row", ovec_t'(o_out_row), ovec_t'(exp_row_q.pop_front()));
            end
        end
        if (o_absmax_valid) am_q.push_back(o_absmax);
        if (o_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cfg_write(input bit sel, input int addr, input cvec_t data);
        i_cfg_we = 1'b1; i_cfg_sel = sel; i_cfg_addr = addr[AW-1:0]; i_cfg_data = data;
        @(posedge i_clk); #1;
        i_cfg_we = 1'b0;
    endtask

    // Runs one job from in_q; exp_q/exp_row_q hold the expected outputs
    task automatic run_job(input int num, input bit relu, input int sh,
                           input bit rv, input bit rr, input bit poke);
        int idx = 0, cb = 0, d0 = done_cnt;
        hs_cyc = -1; first_valid_cyc = -1; am_q.delete();
        i_start = 1'b1; i_num_vec = num[CNT_W-1:0]; i_relu_en = relu; i_shift = sh[SHIFT_W-1:0];
        @(posedge i_clk); #1;
        i_start = 1'b0;
        while (done_cnt == d0 && cb < 3000) begin
            if (in_hs) idx++;
            i_in_valid  = (idx < num) && (!rv || ($urandom_range(0, 1) == 1));
            i_in_data   = (idx < num) ? in_q[idx] : '0;
            i_out_ready = !rr || ($urandom_range(0, 3) != 0);
            i_cfg_we    = poke && (cb == 5);
            i_cfg_sel   = 1'b0; i_cfg_addr = '0; i_cfg_data = '1;
            @(posedge i_clk); #1;
            cb++;
        end
        i_in_valid = 1'b0; i_out_ready = 1'b1; i_cfg_we = 1'b0;
        check("done_seen", ovec_t'(done_cnt - d0), ovec_t'(1));
        check("exp_drained", ovec_t'(exp_q.size()), ovec_t'(0));
        repeat (2) @(posedge i_clk);
        #1;
        check("done_pulse", ovec_t'(done_cnt - d0), ovec_t'(1));
        in_q.delete();
    endtask

    initial begin
        ivec_t iv;
        ovec_t ov;
        int a;
        i_rst_n = 1'b0; i_start = 1'b0; i_num_vec = '0; i_relu_en = 1'b0; i_shift = '0;
        i_cfg_we = 1'b0; i_cfg_sel = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
        i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_flags", ovec_t'({o_busy, o_out_valid, o_in_ready, o_done, o_absmax_valid, o_sat}), ovec_t'(0));
        check("rst_data", o_out_data, ovec_t'(0));
        check("rst_absmax", ovec_t'(o_absmax), ovec_t'(0));
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // scale 1024 written in the same cycle as start, shift 10: 5 -> 5
        cfg_write(1'b1, 0, rep_c(0));
        i_cfg_we = 1'b1; i_cfg_sel = 1'b0; i_cfg_addr = '0; i_cfg_data = rep_c(1024);
        in_q.push_back(rep_i(5)); exp_q.push_back(rep_o(5)); exp_row_q.push_back(4'd0);
        run_job(1, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        check("latency", ovec_t'(first_valid_cyc - hs_cyc), ovec_t'(3));
        check("am_cnt_1", ovec_t'(am_q.size()), ovec_t'(1));
        check("am_val_1", am_at(0), ovec_t'(5));

        // scale 512, shift 10: +3/-3 -> +2/-2; bias 2048 with acc 0 -> 2
        cfg_write(1'b0, 0, rep_c(512)); cfg_write(1'b1, 0, rep_c(0));
        cfg_write(1'b0, 1, rep_c(512)); cfg_write(1'b1, 1, rep_c(2048));
        for (int i = 0; i < VL; i++) begin
            iv[i*ACC_W +: ACC_W] = (i % 2 == 0) ? 24'sd3 : -24'sd3;
            ov[i*OUT_W +: OUT_W] = (i % 2 == 0) ? 18'sd2 : -18'sd2;
        end
        in_q.push_back(iv); exp_q.push_back(ov); exp_row_q.push_back(4'd0);
        in_q.push_back(rep_i(0)); exp_q.push_back(rep_o(2)); exp_row_q.push_back(4'd1);
        run_job(2, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        check("sat_clear_t3", ovec_t'(o_sat), ovec_t'(0));

        // saturation: (2^23-1)*32767, shift 0 -> +/-131071
        cfg_write(1'b0, 0, rep_c(32767)); cfg_write(1'b0, 1, rep_c(32767));
        cfg_write(1'b1, 1, rep_c(0));
        in_q.push_back(rep_i(8388607)); exp_q.push_back(rep_o(131071)); exp_row_q.push_back(4'd0);
        in_q.push_back(rep_i(-8388607)); exp_q.push_back(rep_o(-131071)); exp_row_q.push_back(4'd1);
        run_job(2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("sat_set", ovec_t'(o_sat), ovec_t'(1));

        // ReLU on/off with acc -7, scale 1024, shift 10
        cfg_write(1'b0, 0, rep_c(1024));
        in_q.push_back(rep_i(-7)); exp_q.push_back(rep_o(0)); exp_row_q.push_back(4'd0);
        run_job(1, 1'b1, 10, 1'b0, 1'b0, 1'b0);
        check("sat_cleared", ovec_t'(o_sat), ovec_t'(0));
        in_q.push_back(rep_i(-7)); exp_q.push_back(rep_o(-7)); exp_row_q.push_back(4'd0);
        run_job(1, 1'b0, 10, 1'b0, 1'b0, 1'b0);

        // per-row scales 1..16 over 20 vectors, lane i acc = i+1
        for (int r = 0; r < DEPTH; r++) begin
            cfg_write(1'b0, r, rep_c(r + 1)); cfg_write(1'b1, r, rep_c(0));
        end
        for (int i = 0; i < VL; i++) iv[i*ACC_W +: ACC_W] = ACC_W'(i + 1);
        for (int v = 0; v < 20; v++) begin
            for (int i = 0; i < VL; i++) ov[i*OUT_W +: OUT_W] = OUT_W'((i + 1) * (v % 16 + 1));
            in_q.push_back(iv); exp_q.push_back(ov); exp_row_q.push_back(AW'(v % 16));
        end
        run_job(20, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("am_cnt_tile", ovec_t'(am_q.size()), ovec_t'(2));
        check("am_tile0", am_at(0), ovec_t'(256));
        check("am_tile1", am_at(1), ovec_t'(64));

        // zero-length job completes at once
        run_job(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // random tables, random valid/ready, dropped config write mid-job
        for (int r = 0; r < DEPTH; r++) begin
            cvec_t cs, cb2;
            for (int l = 0; l < VL; l++) begin
                sc_tab[r][l] = int'($urandom_range(0, 4000)) - 2000;
                bi_tab[r][l] = int'($urandom_range(0, 2097152)) - 1048576;
                cs[l*BIAS_W +: BIAS_W]  = sc_tab[r][l];
                cb2[l*BIAS_W +: BIAS_W] = bi_tab[r][l];
            end
            cfg_write(1'b0, r, cs); cfg_write(1'b1, r, cb2);
        end
        for (int v = 0; v < 64; v++) begin
            longint e;
            for (int l = 0; l < VL; l++) begin
                a = int'($urandom_range(0, 2097152)) - 1048576;
                iv[l*ACC_W +: ACC_W] = a[ACC_W-1:0];
                e = ref_lane(longint'(a), longint'(sc_tab[v % 16][l]), longint'(bi_tab[v % 16][l]), 1'b0, 8);
                ov[l*OUT_W +: OUT_W] = e[OUT_W-1:0];
            end
            in_q.push_back(iv); exp_q.push_back(ov); exp_row_q.push_back(AW'(v % 16));
        end
        run_job(64, 1'b0, 8, 1'b1, 1'b1, 1'b1);

        // mid-RUN reset aborts the job, then a fresh job runs normally
        cfg_write(1'b0, 0, rep_c(1024)); cfg_write(1'b1, 0, rep_c(0));
        i_start = 1'b1; i_num_vec = 16'd4; i_relu_en = 1'b0; i_shift = 6'd10;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_in_valid = 1'b1; i_in_data = rep_i(1);
        repeat (2) @(posedge i_clk);
        #1;
        i_in_valid = 1'b0; i_rst_n = 1'b0;
        #1;
        check("abort_flags", ovec_t'({o_busy, o_out_valid, o_in_ready, o_done, o_absmax_valid, o_sat}), ovec_t'(0));
        check("abort_data", o_out_data, ovec_t'(0));
        a = done_cnt;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (8) @(posedge i_clk);
        #1;
        check("abort_no_done", ovec_t'(done_cnt - a), ovec_t'(0));
        in_q.push_back(rep_i(9)); exp_q.push_back(rep_o(9)); exp_row_q.push_back(4'd0);
        run_job(1, 1'b0, 10, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
